regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have no parameters; XLEN fixed at 32, 32 architectural registers, x0 hardwired to zero.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port w_enable  in  1  writeback write strobe.
REQ-005 SHALL have port w_dest  in  5  writeback destination register.
REQ-006 SHALL have port w_data  in  32  writeback data.
REQ-007 SHALL have port mark_enable  in  1  issue marks destination pending.
REQ-008 SHALL have port mark_dest  in  5  register to mark busy.
REQ-009 SHALL have port flush  in  1  clear all pending marks.
REQ-010 SHALL have port rd_valid  in  1  operand read request.
REQ-011 SHALL have ports rs1, rs2  in  5 each  source register indices.
REQ-012 SHALL have port rd_ready  out  1  request acceptable this cycle.
REQ-013 SHALL have port rdata_valid  out  1  operand response strobe.
REQ-014 SHALL have ports rdata1, rdata2  out  32 each  operand values.
REQ-015 SHALL have port busy  out  32  scoreboard vector, bit i = register i pending.

Function
REQ-016 SHALL write regs[w_dest] <= w_data at clock edge when w_enable=1 and w_dest!=0; writes to x0 discarded.
REQ-017 SHALL clear busy[w_dest] on the same edge as an accepted write.
REQ-018 SHALL set busy[mark_dest] when mark_enable=1 and mark_dest!=0; busy[0] is constant 0.
REQ-019 SHALL give mark priority over write-clear when mark_dest==w_dest in the same cycle: data written, busy stays 1.
REQ-020 SHALL clear all busy bits on flush=1; a mark in the same cycle is ignored; a write in the same cycle still updates data.
REQ-021 SHALL drive rd_ready combinationally = !rst && src1_ok && src2_ok, where srcN_ok = !busy[rsN] (extended by REQ-031 when enabled).
REQ-022 SHALL accept a request on an edge where rd_valid && rd_ready; no request queued when rd_ready=0; requester must hold rs1/rs2.
REQ-023 SHALL assert rdata_valid for exactly one cycle, the cycle after acceptance; back-to-back accepts yield consecutive strobes.
REQ-024 SHALL latch rdata1/rdata2 at acceptance edge; they hold until the next acceptance.
REQ-025 SHALL return 0 for any source index 0.
REQ-026 SHALL, without bypass, return the register value before any same-cycle write.
REQ-027 SHALL evaluate rd_ready against busy state before the current edge's marks/clears (a mark this cycle does not stall this cycle's read).

Reset
REQ-028 SHALL on rst=1 at an edge: all registers 0, busy 0, rdata_valid 0, rdata1/rdata2 0; writes, marks and reads in that cycle ignored.
REQ-029 SHALL drop a pending response if rst asserts the cycle after acceptance (rdata_valid 0 that cycle... next cycle).
REQ-030 SHALL hold rd_ready=0 while rst=1.

Configuration
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, treat srcN_ok true when busy[rsN]=1 but w_enable=1 and w_dest==rsN, and latch w_data for that source (write-through forwarding).
REQ-032 SHALL, without REGFILE_BYPASS_EN, have no forwarding path; a busy source stalls until the cycle after writeback clears it.

Verification
REQ-033 SHALL cover: reset, write x5=0xDEADBEEF, read rs1=5 rs2=0 -> rd_ready=1, next cycle rdata_valid=1, rdata1=0xDEADBEEF, rdata2=0.
REQ-034 SHALL cover: write x0=0x12345678 then read rs1=0 -> rdata1=0, busy[0]=0.
REQ-035 SHALL cover: mark x7, request rs2=7 -> rd_ready=0; writeback x7=0xA5A5A5A5 -> bypass: accept that cycle with rdata2=0xA5A5A5A5; no bypass: accept one cycle later, same value.
REQ-036 SHALL cover: mark x3 and write x3=0x1 same cycle -> regs[3]=1, busy[3]=1.
REQ-037 SHALL cover: mark x1,x2,x9 then flush with mark x4 same cycle -> busy=0x00000000.
REQ-038 SHALL cover: accept read, assert rst next cycle -> rdata_valid=0, rdata1=rdata2=0, busy=0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 32 x 32-bit register file with x0 tied to zero, a per-register busy scoreboard and a
// single-cycle two-operand read port. Write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb (
    input  logic        clk,
    input  logic        rst,
    input  logic        w_enable,
    input  logic [4:0]  w_dest,
    input  logic [31:0] w_data,
    input  logic        mark_enable,
    input  logic [4:0]  mark_dest,
    input  logic        flush,
    input  logic        rd_valid,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rd_ready,
    output logic        rdata_valid,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] busy
);

    logic [31:0] regs [32];
    logic [31:0] busy_q;
    logic [31:0] busy_next;
    logic        valid_q;
    logic [31:0] rdata1_q;
    logic [31:0] rdata2_q;

    logic        wr_hit;
    logic        mark_hit;
    logic        src1_ok;
    logic        src2_ok;
    logic        accept;
    logic [31:0] op1;
    logic [31:0] op2;

    assign wr_hit   = w_enable && (w_dest != 5'd0);
    assign mark_hit = mark_enable && (mark_dest != 5'd0);

    // True when this cycle's writeback targets the source and may be forwarded to it.
    function automatic logic fwd_hit(input logic [4:0] idx, input logic wr, input logic [4:0] dest);
`ifdef REGFILE_BYPASS_EN
        return wr && (dest == idx);
`else
        return 1'b0 && wr && (dest == idx);
`endif
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic fwd,
                                            input logic [31:0] stored, input logic [31:0] wdat);
        if (idx == 5'd0) begin
            return 32'd0;
        end else if (fwd) begin
            return wdat;
        end
        return stored;
    endfunction

    // NOTE: every variable in an always_comb gets a default before any condition, so no latch is inferred.
    always_comb begin
        src1_ok = !busy_q[rs1] || fwd_hit(rs1, wr_hit, w_dest);
        src2_ok = !busy_q[rs2] || fwd_hit(rs2, wr_hit, w_dest);
        op1     = operand(rs1, fwd_hit(rs1, wr_hit, w_dest), regs[rs1], w_data);
        op2     = operand(rs2, fwd_hit(rs2, wr_hit, w_dest), regs[rs2], w_data);
    end

    // Readiness looks only at busy state before this edge; marks issued now do not stall this read.
    assign rd_ready = !rst && src1_ok && src2_ok;
    assign accept   = rd_valid && rd_ready;

    // Writeback clears first so a same-register mark wins; flush overrides both.
    always_comb begin
        busy_next = busy_q;
        if (wr_hit) begin
            busy_next[w_dest] = 1'b0;
        end
        if (flush) begin
            busy_next = '0;
        end else if (mark_hit) begin
            busy_next[mark_dest] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: the register array is reset explicitly because reset must return every register to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            busy_q   <= '0;
            valid_q  <= 1'b0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            // NOTE: state is updated with <= so all reads in this block see pre-edge values.
            if (wr_hit) begin
                regs[w_dest] <= w_data;
            end
            busy_q  <= busy_next;
            valid_q <= accept;
            if (accept) begin
                rdata1_q <= op1;
                rdata2_q <= op2;
            end
        end
    end

    // A response due in a reset cycle is suppressed immediately.
    assign rdata_valid = valid_q && !rst;
    assign rdata1      = rdata1_q;
    assign rdata2      = rdata2_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an array/bit-vector reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_enable = 1'b0;
    logic [4:0]  w_dest = '0;
    logic [31:0] w_data = '0;
    logic        mark_enable = 1'b0;
    logic [4:0]  mark_dest = '0;
    logic        flush = 1'b0;
    logic        rd_valid = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rd_ready;
    logic        rdata_valid;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_valid;
    logic [31:0] m_r1;
    logic [31:0] m_r2;
    logic        pre_ready;
    logic        pre_valid;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .w_enable(w_enable), .w_dest(w_dest), .w_data(w_data),
        .mark_enable(mark_enable), .mark_dest(mark_dest), .flush(flush),
        .rd_valid(rd_valid), .rs1(rs1), .rs2(rs2),
        .rd_ready(rd_ready), .rdata_valid(rdata_valid),
        .rdata1(rdata1), .rdata2(rdata2), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd(input logic [4:0] idx, input logic we, input logic [4:0] wd);
        return BYPASS && we && (wd != 5'd0) && (wd == idx);
    endfunction

    function automatic logic src_ok(input logic [4:0] idx, input logic we, input logic [4:0] wd);
        return (idx == 5'd0) || !m_busy[idx] || fwd(idx, we, wd);
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic we, input logic [4:0] wd,
                                            input logic [31:0] wdat);
        if (idx == 5'd0) return 32'd0;
        if (fwd(idx, we, wd)) return wdat;
        return m_regs[idx];
    endfunction

    // One clock: drive inputs at negedge, check combinational outputs, update the model, check after the edge.
    task automatic cycle(input logic r, input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                         input logic me, input logic [4:0] md, input logic fl,
                         input logic rv, input logic [4:0] a, input logic [4:0] b);
        logic        exp_ready;
        logic [31:0] v1;
        logic [31:0] v2;
        @(negedge clk);
        rst = r; w_enable = we; w_dest = wd; w_data = wdat;
        mark_enable = me; mark_dest = md; flush = fl;
        rd_valid = rv; rs1 = a; rs2 = b;
        #1;
        exp_ready = !r && src_ok(a, we, wd) && src_ok(b, we, wd);
        v1 = src_val(a, we, wd, wdat);
        v2 = src_val(b, we, wd, wdat);
        pre_ready = rd_ready;
        pre_valid = rdata_valid;
        chk("rd_ready", {31'd0, rd_ready}, {31'd0, exp_ready});
        chk("valid_pre", {31'd0, rdata_valid}, {31'd0, m_valid && !r});
        chk("busy_pre", busy, m_busy);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0; m_valid = 1'b0; m_r1 = '0; m_r2 = '0;
        end else begin
            m_valid = rv && exp_ready;
            if (m_valid) begin
                m_r1 = v1;
                m_r2 = v2;
            end
            if (we && wd != 5'd0) begin
                m_regs[wd] = wdat;
                m_busy[wd] = 1'b0;
            end
            if (fl) m_busy = '0;
            else if (me && md != 5'd0) m_busy[md] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, m_valid});
        chk("rdata1", rdata1, m_r1);
        chk("rdata2", rdata2, m_r2);
        chk("busy", busy, m_busy);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0; m_valid = 1'b0; m_r1 = '0; m_r2 = '0;
        chk("reset_ready", {31'd0, rd_ready}, 32'd0);
        chk("reset_valid", {31'd0, rdata_valid}, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);

        // Write x5 then read it with rs2=x0.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 5'd0);
        chk("t33_ready", {31'd0, pre_ready}, 32'd1);
        chk("t33_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t33_rdata1", rdata1, 32'hDEADBEEF);
        chk("t33_rdata2", rdata2, 32'd0);
        idle();
        chk("t33_strobe_once", {31'd0, rdata_valid}, 32'd0);
        chk("t33_hold", rdata1, 32'hDEADBEEF);

        // Writes to x0 are discarded.
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd5);
        chk("t34_rdata1", rdata1, 32'd0);
        chk("t34_busy0", busy & 32'd1, 32'd0);

        // Busy source stall and release through writeback.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7);
        chk("t35_stall", {31'd0, pre_ready}, 32'd0);
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7);
        chk("t35_wb_ready", {31'd0, pre_ready}, {31'd0, BYPASS});
        if (!BYPASS) begin
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7);
            chk("t35_late_ready", {31'd0, pre_ready}, 32'd1);
        end
        chk("t35_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t35_rdata2", rdata2, 32'hA5A5A5A5);

        // Mark and write the same register in one cycle.
        cycle(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0);
        chk("t36_busy3", (busy >> 3) & 32'd1, 32'd1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 5'd0);
        chk("t36_regs3", rdata1, 32'h1);

        // A mark issued this cycle does not stall this cycle's read.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b1, 5'd6, 5'd5);
        chk("t27_ready", {31'd0, pre_ready}, 32'd1);

        // Flush wins over a same-cycle mark.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("t37_busy", busy, 32'd0);

        // Reset the cycle after an accepted read.
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 1'b1, 5'd5, 5'd3);
        cycle(1'b1, 1'b1, 5'd5, 32'hFFFF0000, 1'b1, 5'd2, 1'b0, 1'b1, 5'd5, 5'd3);
        chk("t38_ready_rst", {31'd0, pre_ready}, 32'd0);
        chk("t38_valid_drop", {31'd0, pre_valid}, 32'd0);
        chk("t38_rdata1", rdata1, 32'd0);
        chk("t38_rdata2", rdata2, 32'd0);
        chk("t38_busy", busy, 32'd0);

        // Randomized traffic on a small register window to force collisions.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
